// File: rtl/wb_mbox_pkg.sv
// rtl/wb_mbox_pkg.sv - shared constants and helpers for the Wishbone mailbox FIFO
package wb_mbox_pkg;

    // Value of wb_adr_i[2] selecting each register
    localparam logic ADR_DATA   = 1'b0;
    localparam logic ADR_STATUS = 1'b1;

    // STATUS word layout; rx_count occupies the low bits from bit 0
    localparam int STATUS_OVF_BIT   = 31;
    localparam int STATUS_UNF_BIT   = 30;
    localparam int STATUS_TXCNT_LSB = 16;

    // Expand 4 byte selects into a 32-bit data mask
    function automatic logic [31:0] byte_mask(input logic [3:0] sel);
        logic [31:0] mask;
        for (int i = 0; i < 4; i++) begin
            mask[8*i +: 8] = {8{sel[i]}};
        end
        return mask;
    endfunction

endpackage

// File: rtl/mbox_sync_fifo.sv
// rtl/mbox_sync_fifo.sv - single-clock first-word-fall-through FIFO with pre-edge full/empty
//
// Ports:
//   clk, rst      clock, asynchronous active-high reset
//   push, wdata   write request; ignored while full (full is the pre-edge state)
//   pop           read request; ignored while empty (empty is the pre-edge state)
//   rdata         head word, valid whenever empty is low
//   count         number of stored words (0 .. 2**DEPTH_LOG2)
//   full, empty   decoded from the registered count
module mbox_sync_fifo #(
    parameter  int DEPTH_LOG2 = 4,
    localparam int CW         = DEPTH_LOG2 + 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push,
    input  logic          pop,
    input  logic [31:0]   wdata,
    output logic [31:0]   rdata,
    output logic [CW-1:0] count,
    output logic          full,
    output logic          empty
);

    localparam int DEPTH = 1 << DEPTH_LOG2;

    logic [31:0]           mem [DEPTH];
    logic [DEPTH_LOG2-1:0] wr_ptr;
    logic [DEPTH_LOG2-1:0] rd_ptr;
    logic                  do_push;
    logic                  do_pop;

    assign full  = (count == CW'(DEPTH));
    assign empty = (count == '0);

    // A pop on a full FIFO does not make room for a push on the same edge
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;

    assign rdata = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= wdata;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/wb_mbox_fifo.sv
// rtl/wb_mbox_fifo.sv - Wishbone classic slave mailbox with TX/RX FIFOs and status word
//
// Build option: define MBOX_ERR_EN to answer writes to a full TX FIFO and
// reads of an empty RX FIFO with wb_err_o (no side effect, no flag) instead
// of dropping/zero-filling with the sticky ovf/unf flags.
//
// Ports:
//   clk_i, rst_i        clock, asynchronous active-high reset
//   wb_*                Wishbone classic slave; wb_adr_i[2] selects DATA(0)/STATUS(1)
//   tx_valid_o/tx_data_o/tx_ready_i   TX stream out, head word shown while valid
//   rx_valid_i/rx_data_i/rx_ready_o   RX stream in, accepted while not full
module wb_mbox_fifo
    import wb_mbox_pkg::*;
#(
    parameter int DEPTH_LOG2 = 4
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        wb_cyc_i,
    input  logic        wb_stb_i,
    input  logic [31:0] wb_adr_i,
    input  logic [3:0]  wb_sel_i,
    input  logic        wb_we_i,
    input  logic [31:0] wb_dat_i,
    output logic [31:0] wb_dat_o,
    output logic        wb_ack_o,
    output logic        wb_err_o,
    output logic        wb_stall_o,
    output logic        tx_valid_o,
    output logic [31:0] tx_data_o,
    input  logic        tx_ready_i,
    input  logic        rx_valid_i,
    input  logic [31:0] rx_data_i,
    output logic        rx_ready_o
);

    localparam int CW = DEPTH_LOG2 + 1;

`ifdef MBOX_ERR_EN
    localparam bit ERR_EN = 1'b1;
`else
    localparam bit ERR_EN = 1'b0;
`endif

    logic          req;
    logic          is_status;
    logic          tx_push;
    logic          rx_pop;
    logic          bad_req;
    logic [31:0]   rx_rdata;
    logic [CW-1:0] tx_count;
    logic [CW-1:0] rx_count;
    logic          tx_full;
    logic          tx_empty;
    logic          rx_full;
    logic          rx_empty;
    logic          ovf;
    logic          unf;
    logic [31:0]   status_word;
    logic          unused_adr;

    assign unused_adr = ^{wb_adr_i[31:3], wb_adr_i[1:0]};

    // The ack/err cycle itself is never taken as a new request
    assign req       = wb_cyc_i & wb_stb_i & ~wb_ack_o & ~wb_err_o;
    assign is_status = (wb_adr_i[2] == ADR_STATUS);

    // A full TX write or empty RX read; FIFOs already ignore these, so the
    // only effect of bad_req is choosing err vs. ack/flag.
    assign bad_req = req & ~is_status & (wb_we_i ? tx_full : rx_empty);

    assign tx_push = req & wb_we_i & ~is_status;
    assign rx_pop  = req & ~wb_we_i & ~is_status;

    mbox_sync_fifo #(.DEPTH_LOG2(DEPTH_LOG2)) u_tx_fifo (
        .clk   (clk_i),
        .rst   (rst_i),
        .push  (tx_push),
        .pop   (tx_ready_i),
        .wdata (wb_dat_i & byte_mask(wb_sel_i)),
        .rdata (tx_data_o),
        .count (tx_count),
        .full  (tx_full),
        .empty (tx_empty)
    );

    mbox_sync_fifo #(.DEPTH_LOG2(DEPTH_LOG2)) u_rx_fifo (
        .clk   (clk_i),
        .rst   (rst_i),
        .push  (rx_valid_i),
        .pop   (rx_pop),
        .wdata (rx_data_i),
        .rdata (rx_rdata),
        .count (rx_count),
        .full  (rx_full),
        .empty (rx_empty)
    );

    assign tx_valid_o = ~tx_empty;
    assign rx_ready_o = ~rx_full;
    assign wb_stall_o = 1'b0;

    always_comb begin
        status_word                              = '0;
        status_word[CW-1:0]                      = rx_count;
        status_word[STATUS_TXCNT_LSB +: CW]      = tx_count;
        status_word[STATUS_OVF_BIT]              = ovf;
        status_word[STATUS_UNF_BIT]              = unf;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wb_ack_o <= 1'b0;
            wb_err_o <= 1'b0;
            wb_dat_o <= '0;
            ovf      <= 1'b0;
            unf      <= 1'b0;
        end else begin
            wb_ack_o <= 1'b0;
            wb_err_o <= 1'b0;
            if (req) begin
                if (ERR_EN && bad_req) begin
                    wb_err_o <= 1'b1;
                end else begin
                    wb_ack_o <= 1'b1;
                    if (!is_status) begin
                        if (wb_we_i) begin
                            if (tx_full) begin
                                ovf <= 1'b1;
                            end
                        end else if (rx_empty) begin
                            wb_dat_o <= '0;
                            unf      <= 1'b1;
                        end else begin
                            wb_dat_o <= rx_rdata;
                        end
                    end else if (wb_we_i) begin
                        // Flags are write-one-to-clear through the top byte lane only
                        if (wb_sel_i[3]) begin
                            if (wb_dat_i[STATUS_OVF_BIT]) ovf <= 1'b0;
                            if (wb_dat_i[STATUS_UNF_BIT]) unf <= 1'b0;
                        end
                    end else begin
                        wb_dat_o <= status_word;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_wb_mbox_fifo.sv
// tb/tb_wb_mbox_fifo.sv - scoreboard testbench for wb_mbox_fifo
module tb_wb_mbox_fifo;

    localparam int DL2   = 2;
    localparam int DEPTH = 4;

`ifdef MBOX_ERR_EN
    localparam bit ERR_EN = 1'b1;
`else
    localparam bit ERR_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_i = 1'b1;
    logic        wb_cyc_i = 1'b0;
    logic        wb_stb_i = 1'b0;
    logic [31:0] wb_adr_i = '0;
    logic [3:0]  wb_sel_i = '0;
    logic        wb_we_i = 1'b0;
    logic [31:0] wb_dat_i = '0;
    logic [31:0] wb_dat_o;
    logic        wb_ack_o;
    logic        wb_err_o;
    logic        wb_stall_o;
    logic        tx_valid_o;
    logic [31:0] tx_data_o;
    logic        tx_ready_i = 1'b0;
    logic        rx_valid_i = 1'b0;
    logic [31:0] rx_data_i = '0;
    logic        rx_ready_o;

    always #5 clk = ~clk;

    wb_mbox_fifo #(.DEPTH_LOG2(DL2)) dut (
        .clk_i      (clk),
        .rst_i      (rst_i),
        .wb_cyc_i   (wb_cyc_i),
        .wb_stb_i   (wb_stb_i),
        .wb_adr_i   (wb_adr_i),
        .wb_sel_i   (wb_sel_i),
        .wb_we_i    (wb_we_i),
        .wb_dat_i   (wb_dat_i),
        .wb_dat_o   (wb_dat_o),
        .wb_ack_o   (wb_ack_o),
        .wb_err_o   (wb_err_o),
        .wb_stall_o (wb_stall_o),
        .tx_valid_o (tx_valid_o),
        .tx_data_o  (tx_data_o),
        .tx_ready_i (tx_ready_i),
        .rx_valid_i (rx_valid_i),
        .rx_data_i  (rx_data_i),
        .rx_ready_o (rx_ready_o)
    );

    int passed = 0;
    int total  = 0;

    typedef struct {
        bit ack;
        bit err;
        bit tx_valid;
        bit rx_ready;
    } cyc_t;

    typedef struct {
        bit          is_err;
        bit          chk;
        logic [31:0] dat;
    } resp_t;

    // Reference model state: mailbox contents as plain queues
    logic [31:0] m_tx[$];
    logic [31:0] m_rx[$];
    logic [31:0] tx_exp[$];
    cyc_t        cyc_q[$];
    resp_t       resp_q[$];
    bit          m_ovf = 0;
    bit          m_unf = 0;
    bit          m_ack = 0;
    bit          m_err = 0;
    bit          mon_en = 0;

    int txr_mode = 0;   // 0 low, 1 high, 2 random
    bit rx_rand  = 0;
    int tx_prob  = 50;
    int rx_prob  = 50;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    endtask

    task automatic model_reset();
        m_tx.delete();
        m_rx.delete();
        tx_exp.delete();
        cyc_q.delete();
        resp_q.delete();
        m_ovf = 0;
        m_unf = 0;
        m_ack = 0;
        m_err = 0;
    endtask

    // Predict the effect of the coming clock edge from the inputs just driven
    task automatic model_edge();
        bit          req;
        bit          tx_full;
        bit          rx_full;
        bit          rx_empty;
        logic [31:0] st;
        logic [31:0] w;
        cyc_t        c;
        resp_t       r;
        c.ack      = m_ack;
        c.err      = m_err;
        c.tx_valid = (m_tx.size() != 0);
        c.rx_ready = (m_rx.size() < DEPTH);
        cyc_q.push_back(c);
        req      = wb_cyc_i && wb_stb_i && !m_ack && !m_err;
        tx_full  = (m_tx.size() == DEPTH);
        rx_full  = (m_rx.size() == DEPTH);
        rx_empty = (m_rx.size() == 0);
        st = {m_ovf, m_unf, 30'(0)} | (32'(m_tx.size()) << 16) | 32'(m_rx.size());
        m_ack = 0;
        m_err = 0;
        if (tx_ready_i && m_tx.size() > 0) tx_exp.push_back(m_tx.pop_front());
        if (req) begin
            r.is_err = 0;
            r.chk    = 0;
            r.dat    = '0;
            if (!wb_adr_i[2]) begin
                if (wb_we_i) begin
                    if (tx_full) begin
                        if (ERR_EN) r.is_err = 1;
                        else m_ovf = 1;
                    end else begin
                        w = '0;
                        for (int i = 0; i < 4; i++)
                            if (wb_sel_i[i]) w[8*i +: 8] = wb_dat_i[8*i +: 8];
                        m_tx.push_back(w);
                    end
                end else if (rx_empty) begin
                    if (ERR_EN) r.is_err = 1;
                    else begin
                        m_unf = 1;
                        r.chk = 1;
                    end
                end else begin
                    r.chk = 1;
                    r.dat = m_rx.pop_front();
                end
            end else if (wb_we_i) begin
                if (wb_sel_i[3]) begin
                    if (wb_dat_i[31]) m_ovf = 0;
                    if (wb_dat_i[30]) m_unf = 0;
                end
            end else begin
                r.chk = 1;
                r.dat = st;
            end
            m_ack = !r.is_err;
            m_err = r.is_err;
            resp_q.push_back(r);
        end
        if (rx_valid_i && !rx_full) m_rx.push_back(rx_data_i);
    endtask

    task automatic step(input bit stb, input bit we, input logic [31:0] adr, input logic [3:0] sel,
                        input logic [31:0] dat, input bit rxv, input logic [31:0] rxd);
        @(posedge clk);
        #1;
        mon_en   = 1;
        wb_cyc_i = stb;
        wb_stb_i = stb;
        wb_we_i  = we;
        wb_adr_i = adr;
        wb_sel_i = sel;
        wb_dat_i = dat;
        if (txr_mode == 2) tx_ready_i = ($urandom_range(99) < tx_prob);
        else tx_ready_i = (txr_mode == 1);
        if (rx_rand) begin
            rx_valid_i = ($urandom_range(99) < rx_prob);
            rx_data_i  = $urandom;
        end else begin
            rx_valid_i = rxv;
            rx_data_i  = rxd;
        end
        model_edge();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, '0, '0, '0, 0, '0);
    endtask

    // Request cycle then ack cycle; hold keeps stb high through the ack
    task automatic bus(input bit we, input logic [31:0] adr, input logic [3:0] sel,
                       input logic [31:0] dat, input bit hold);
        step(1, we, adr, sel, dat, 0, '0);
        step(hold, we, adr, sel, dat, 0, '0);
    endtask

    task automatic bus_rd_lit(input string name, input logic [31:0] adr, input logic [31:0] lit);
        bus(0, adr, 4'hF, '0, 1);
        check(name, wb_dat_o, lit);
    endtask

    always @(negedge clk) begin
        cyc_t  e;
        resp_t r;
        if (mon_en) begin
            if (cyc_q.size() == 0) begin
                total++;
                $display("FAIL cyc_queue: no expectation for this cycle");
            end else begin
                e = cyc_q.pop_front();
                check("ack", wb_ack_o, e.ack);
                check("err", wb_err_o, e.err);
                check("tx_valid", tx_valid_o, e.tx_valid);
                check("rx_ready", rx_ready_o, e.rx_ready);
            end
            check("stall", wb_stall_o, 0);
            if (wb_ack_o || wb_err_o) begin
                if (resp_q.size() == 0) begin
                    total++;
                    $display("FAIL resp: unexpected response ack=%0b err=%0b", wb_ack_o, wb_err_o);
                end else begin
                    r = resp_q.pop_front();
                    check("resp_kind", wb_err_o, r.is_err);
                    if (r.chk) check("rd_data", wb_dat_o, r.dat);
                end
            end
            if (tx_valid_o && tx_ready_i) begin
                if (tx_exp.size() == 0) begin
                    total++;
                    $display("FAIL tx_stream: unexpected word 0x%08h", tx_data_o);
                end else begin
                    check("tx_data", tx_data_o, tx_exp.pop_front());
                end
            end
        end
    end

    initial begin
        repeat (3) @(posedge clk);
        #1;
        check("rst_ack", wb_ack_o, 0);
        check("rst_err", wb_err_o, 0);
        check("rst_dat", wb_dat_o, 0);
        check("rst_tx_valid", tx_valid_o, 0);
        check("rst_rx_ready", rx_ready_o, 1);
        @(negedge clk);
        rst_i = 0;

        // Single write, FWFT head, status
        txr_mode = 0;
        bus(1, 32'h0, 4'hF, 32'h12345678, 1);
        check("t1_tx_valid", tx_valid_o, 1);
        check("t1_tx_data", tx_data_o, 32'h12345678);
        bus_rd_lit("t1_status", 32'h4, 32'h00010000);

        // Byte-masked write
        bus(1, 32'h0, 4'h5, 32'hAABBCCDD, 0);
        txr_mode = 1;
        idle(1);
        txr_mode = 0;
        idle(1);
        check("t2_tx_data", tx_data_o, 32'h00BB00DD);
        txr_mode = 1;
        idle(2);
        txr_mode = 0;

        // Overfill TX, drain, clear ovf
        for (int i = 1; i <= 5; i++) bus(1, 32'h0, 4'hF, 32'(i), 1);
        bus_rd_lit("t3_status", 32'h4, ERR_EN ? 32'h00040000 : 32'h80040000);
        txr_mode = 1;
        idle(5);
        txr_mode = 0;
        bus(1, 32'h4, 4'hF, 32'h80000000, 1);
        bus_rd_lit("t3_cleared", 32'h4, 32'h0);

        // RX reads, underflow, W1C lane gating
        step(0, 0, '0, '0, '0, 1, 32'hA);
        step(0, 0, '0, '0, '0, 1, 32'hB);
        idle(1);
        bus_rd_lit("t4_rd0", 32'h0, 32'hA);
        bus_rd_lit("t4_rd1", 32'h0, 32'hB);
        bus_rd_lit("t4_rd2", 32'h0, ERR_EN ? 32'hB : 32'h0);
        bus(1, 32'h4, 4'h7, 32'hC0000000, 1);
        bus_rd_lit("t4_unf_kept", 32'h4, ERR_EN ? 32'h0 : 32'h40000000);
        bus(1, 32'h4, 4'h8, 32'h40000000, 0);
        bus_rd_lit("t4_unf_clr", 32'h4, 32'h0);

        // Full TX: pop and write on the same edge
        for (int i = 0; i < 4; i++) bus(1, 32'h0, 4'hF, 32'h11 + 32'(i), 1);
        txr_mode = 1;
        step(1, 1, 32'h0, 4'hF, 32'h55, 0, '0);
        txr_mode = 0;
        step(1, 1, 32'h0, 4'hF, 32'h55, 0, '0);
        bus_rd_lit("t5_status", 32'h4, ERR_EN ? 32'h00030000 : 32'h80030000);
        bus(1, 32'h4, 4'hF, 32'hC0000000, 1);
        txr_mode = 1;
        idle(4);
        txr_mode = 0;

        // Reset right after a write is sampled
        step(1, 1, 32'h0, 4'hF, 32'hDEADBEEF, 0, '0);
        @(posedge clk);
        #1;
        mon_en   = 0;
        rst_i    = 1;
        wb_cyc_i = 0;
        wb_stb_i = 0;
        #1;
        check("t6_ack_in_rst", wb_ack_o, 0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_i = 0;
        model_reset();
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("t6_no_ack", wb_ack_o, 0);
            check("t6_no_err", wb_err_o, 0);
        end
        check("t6_tx_valid", tx_valid_o, 0);
        check("t6_rx_ready", rx_ready_o, 1);
        bus_rd_lit("t6_status", 32'h4, 32'h0);

        // Randomized traffic against the model
        txr_mode = 2;
        rx_rand  = 1;
        for (int seg = 0; seg < 3; seg++) begin
            tx_prob = (seg == 0) ? 15 : (seg == 1) ? 85 : 50;
            rx_prob = (seg == 0) ? 85 : (seg == 1) ? 15 : 50;
            for (int n = 0; n < 150; n++) begin
                logic [31:0] adr;
                adr    = $urandom;
                adr[2] = ($urandom_range(3) == 0);
                if ($urandom_range(3) == 0) idle(1);
                else bus($urandom_range(1) == 1, adr, 4'($urandom), $urandom, $urandom_range(1) == 1);
            end
        end

        txr_mode = 0;
        rx_rand  = 0;
        idle(3);
        @(negedge clk);
        #1;
        mon_en = 0;
        check("resp_q_drained", 32'(resp_q.size()), 0);
        check("tx_exp_drained", 32'(tx_exp.size()), 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/wb_mbox_fifo.md
Name: wb_mbox_fifo

Overview:
Wishbone classic slave that terminates the "sub" master port of the upstream register block. It implements a two-direction mailbox.
- Bus writes push words into a TX FIFO that drains to a local valid/ready stream.
- Bus reads pop words from an RX FIFO filled by a local valid/ready stream.
- A status word exposes FIFO levels and sticky overflow/underflow flags.

Parameters:
DEPTH_LOG2, 4, log2 of entries per FIFO; legal range 1..8. Count width CW = DEPTH_LOG2+1.

Ports:
clk_i  in  1  clock
rst_i  in  1  asynchronous reset, active-high
wb_cyc_i  in  1  bus cycle
wb_stb_i  in  1  strobe
wb_adr_i  in  32  byte address; only bit 2 decoded (0 = DATA, 1 = STATUS)
wb_sel_i  in  4  byte selects
wb_we_i  in  1  write enable
wb_dat_i  in  32  write data
wb_dat_o  out  32  read data
wb_ack_o  out  1  acknowledge
wb_err_o  out  1  error
wb_stall_o  out  1  always 0
tx_valid_o  out  1  TX FIFO not empty
tx_data_o  out  32  TX head word (first-word fall-through)
tx_ready_i  in  1  consumer pops TX on valid&ready
rx_valid_i  in  1  producer word valid
rx_data_i  in  32  producer word
rx_ready_o  out  1  RX FIFO not full

Behaviour:
Interface decisions:
- One clock, clk_i.
- rst_i is asynchronous and active-high.

Reset:
- wb_ack_o, wb_err_o, tx_valid_o = 0.
- wb_dat_o = 0.
- rx_ready_o = 1 after reset release.
- Both FIFOs empty; both flags clear.
- Reset asserted mid-transaction discards the transaction. No ack/err follows reset release.

Request sampling:
- A request is sampled on the rising edge where wb_cyc_i & wb_stb_i & ~wb_ack_o & ~wb_err_o.
- wb_ack_o (or wb_err_o) is high for exactly one cycle after that edge. Fixed latency is 1.
- The ack cycle, with stb still high, is never re-sampled. Back-to-back requests complete every 2 cycles.
- The side effect occurs on the sampling edge. If stb drops before ack, the effect stands and the ack is still issued.

DATA write:
- Pushes (wb_dat_i AND byte mask from wb_sel_i) into TX. Unselected bytes are stored as 0.
- TX "full" uses the pre-edge count (count == 2^DEPTH_LOG2). A same-cycle tx_ready_i pop does not make room.
- Write to full TX: word dropped, ovf flag set, ack issued.

DATA read:
- Pops the RX head into wb_dat_o on the sampling edge.
- Read from empty RX: wb_dat_o = 0, unf flag set, ack issued.

STATUS read:
- [CW-1:0] rx_count
- [16+CW-1:16] tx_count
- [30] unf
- [31] ovf
- All other bits 0.

STATUS write:
- W1C on bit 31 (ovf) and bit 30 (unf), only when wb_sel_i[3] = 1.
- Other bits ignored.

Stream sides:
- tx_valid_o and rx_ready_o are derived from registered counts.
- A word pushed at edge k is visible on tx_valid_o in cycle k+1.
- Simultaneous push and pop on the same FIFO: count unchanged, data order preserved.
- RX push uses the pre-edge full check.

Counts and pointers:
- Pointers are DEPTH_LOG2 bits and wrap modulo depth.
- Counts saturate nowhere; overflow is impossible by construction.

wb_err_o is 0 except under MBOX_ERR_EN.

Optional Feature:
Macro MBOX_ERR_EN.
- Defined:
  - Write to full TX or read of empty RX responds with wb_err_o instead of wb_ack_o, same 1-cycle latency.
  - No push/pop; wb_dat_o unchanged.
  - ovf/unf never set (bits read 0).
- Undefined: drop/zero-and-flag behaviour as above; wb_err_o tied 0.

Decomposition:
Package wb_mbox_pkg holds:
- ADR_DATA / ADR_STATUS bit-2 values
- STATUS_OVF_BIT = 31, STATUS_UNF_BIT = 30, STATUS_TXCNT_LSB = 16
- BYTE_MASK function (sel to 32-bit mask)

Sub-module mbox_sync_fifo, instantiated twice (TX, RX):
- Parameters: DEPTH_LOG2.
- Ports: push, pop, wdata, rdata, count, full, empty.
- Pre-edge full/empty semantics, FWFT.

Test Plan:
1. Reset, write DATA 0x12345678 sel=0xF with tx_ready_i = 0 -> ack 1 cycle later; tx_valid_o = 1 next cycle; tx_data_o = 0x12345678; STATUS read = 0x00010000.
2. Write DATA 0xAABBCCDD sel=0x5 -> tx_data_o = 0x00BB00DD.
3. DEPTH_LOG2 = 2, 5 writes 1..5 with tx_ready_i = 0 -> fifth dropped; STATUS = 0x80040000. Drain with tx_ready_i = 1 -> data 1,2,3,4. Write STATUS 0x80000000 -> ovf cleared.
4. rx_valid_i pulses data 0xA, 0xB; bus reads DATA twice -> 0xA then 0xB. Third read -> 0x0 with unf = 1. Under MBOX_ERR_EN, third read gives wb_err_o = 1, wb_ack_o = 0.
5. Full TX with tx_ready_i = 1 and bus write on the same edge -> write dropped, ovf set, one word popped (count 3).
6. Assert rst_i in the cycle after a write is sampled -> no ack afterwards, counts 0, tx_valid_o = 0, rx_ready_o = 1.
